// File: rtl/alarm_clock_multi.sv
`default_nettype none
// ============================================================================
// Module      : alarm_clock_multi
// Description : Multi-channel alarm clock controller. Any armed channel whose
//               request is active starts a ringing episode; the user may
//               snooze (bounded count, fixed interval), get up, or let the
//               alarm lapse into AWAKE_IN_BED. day_clr starts a new day.
//               Optional snooze feature is enabled by macro ALARM_SNOOZE_EN;
//               without it the snooze input is ignored and snooze_cnt is 0.
// Ports       : clk        - clock, all state changes on posedge
//               reset      - asynchronous reset, active low
//               alarm_in   - per-channel alarm request (level)
//               alarm_mask - per-channel arm enable (1 = armed)
//               weekday    - working day, forces get-up from AWAKE_IN_BED
//               snooze     - snooze button
//               get_up     - user-up button
//               day_clr    - synchronous return to ASLEEP
//               alarm_out  - ringing indication (Moore)
//               state      - current state code
//               alarm_src  - channels that started the current episode
//               snooze_cnt - snoozes used in the current episode
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_clock_multi #(
    parameter int N_ALARMS      = 4,
    parameter int SNOOZE_CYCLES = 8,
    parameter int MAX_SNOOZE    = 3,
    parameter int CNT_W         = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_ALARMS-1:0] alarm_in,
    input  logic [N_ALARMS-1:0] alarm_mask,
    input  logic                weekday,
    input  logic                snooze,
    input  logic                get_up,
    input  logic                day_clr,
    output logic                alarm_out,
    output logic [2:0]          state,
    output logic [N_ALARMS-1:0] alarm_src,
    output logic [CNT_W-1:0]    snooze_cnt
);

    // State codes are part of the external interface (visible on 'state').
    localparam logic [2:0] c_ASLEEP       = 3'd0;
    localparam logic [2:0] c_RINGING      = 3'd1;
    localparam logic [2:0] c_AWAKE_IN_BED = 3'd3;
    localparam logic [2:0] c_AWAKE_AND_UP = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [N_ALARMS-1:0] r_alarm_src;
    logic [N_ALARMS-1:0] w_alarm_src_nxt;
    logic [N_ALARMS-1:0] w_hits;
    logic                w_hit;

    // Only armed channels can influence the controller.
    assign w_hits = alarm_in & alarm_mask;
    assign w_hit  = |w_hits;

`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0]       c_SNOOZING   = 3'd2;
    // Timer is loaded with SNOOZE_CYCLES-1 and re-rings on the edge after it
    // reaches zero, giving exactly SNOOZE_CYCLES quiet cycles.
    localparam logic [CNT_W-1:0] c_TIMER_LOAD = CNT_W'(SNOOZE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_MAX_SNOOZE = CNT_W'(MAX_SNOOZE);

    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] r_snooze_cnt;
    logic [CNT_W-1:0] w_snooze_cnt_nxt;
`else
    // Snooze feature absent: these inputs/parameters have no function.
    logic w_unused_snooze;
    assign w_unused_snooze = ^{snooze, CNT_W'(SNOOZE_CYCLES), CNT_W'(MAX_SNOOZE)};
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ASLEEP;
            r_alarm_src  <= '0;
`ifdef ALARM_SNOOZE_EN
            r_timer      <= '0;
            r_snooze_cnt <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_alarm_src  <= w_alarm_src_nxt;
`ifdef ALARM_SNOOZE_EN
            r_timer      <= w_timer_nxt;
            r_snooze_cnt <= w_snooze_cnt_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_alarm_src_nxt  = r_alarm_src;
`ifdef ALARM_SNOOZE_EN
        w_timer_nxt      = r_timer;
        w_snooze_cnt_nxt = r_snooze_cnt;
`endif
        if (day_clr) begin
            // New day overrides everything and drops all episode context.
            w_state_nxt      = c_ASLEEP;
            w_alarm_src_nxt  = '0;
`ifdef ALARM_SNOOZE_EN
            w_timer_nxt      = '0;
            w_snooze_cnt_nxt = '0;
`endif
        end else begin
            case (r_state)
                c_ASLEEP: begin
                    if (w_hit) begin
                        w_state_nxt      = c_RINGING;
                        w_alarm_src_nxt  = w_hits;
`ifdef ALARM_SNOOZE_EN
                        w_snooze_cnt_nxt = '0;
`endif
                    end
                end
                c_RINGING: begin
                    if (get_up) begin
                        w_state_nxt = c_AWAKE_AND_UP;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze && (r_snooze_cnt < c_MAX_SNOOZE)) begin
                        // Saturating: a snooze at the limit falls through.
                        w_state_nxt      = c_SNOOZING;
                        w_timer_nxt      = c_TIMER_LOAD;
                        w_snooze_cnt_nxt = r_snooze_cnt + CNT_W'(1);
`endif
                    end else if (!w_hit) begin
                        w_state_nxt = c_AWAKE_IN_BED;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                c_SNOOZING: begin
                    // Alarm requests are deliberately ignored while snoozing.
                    if (get_up) begin
                        w_state_nxt = c_AWAKE_AND_UP;
                    end else if (r_timer == '0) begin
                        w_state_nxt = c_RINGING;
                    end else begin
                        w_timer_nxt = r_timer - CNT_W'(1);
                    end
                end
`endif
                c_AWAKE_IN_BED: begin
                    if (weekday) begin
                        w_state_nxt = c_AWAKE_AND_UP;
                    end else if (w_hit) begin
                        // Re-ring keeps source bitmap and snooze budget.
                        w_state_nxt = c_RINGING;
                    end
                end
                c_AWAKE_AND_UP: begin
                    w_state_nxt = c_AWAKE_AND_UP;
                end
                default: begin
                    // Illegal codes recover to ASLEEP on the next edge.
                    w_state_nxt = c_ASLEEP;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (decoded from registers only)
    // ------------------------------------------------------------------
    assign alarm_out = (r_state == c_RINGING);
    assign state     = r_state;
    assign alarm_src = r_alarm_src;
`ifdef ALARM_SNOOZE_EN
    assign snooze_cnt = r_snooze_cnt;
`else
    assign snooze_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alarm_clock_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_clock_multi
// Description : Self-checking bench for alarm_clock_multi. Directed steps
//               followed by a randomized phase, all compared every cycle
//               against a behavioural reference model. Expected snooze
//               behaviour follows macro ALARM_SNOOZE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_clock_multi;

    localparam int N    = 4;
    localparam int SNZC = 8;
    localparam int MAXS = 3;
    localparam int W    = 4;

    localparam int ASLEEP   = 0;
    localparam int RINGING  = 1;
    localparam int SNOOZING = 2;
    localparam int IN_BED   = 3;
    localparam int UP       = 4;

`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] alarm_in;
    logic [N-1:0] alarm_mask;
    logic         weekday;
    logic         snooze;
    logic         get_up;
    logic         day_clr;
    logic         alarm_out;
    logic [2:0]   state;
    logic [N-1:0] alarm_src;
    logic [W-1:0] snooze_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: mode, episode source, snoozes used, cycles into snooze.
    int           m_state;
    logic [N-1:0] m_src;
    int           m_cnt;
    int           m_since;

    alarm_clock_multi #(
        .N_ALARMS     (N),
        .SNOOZE_CYCLES(SNZC),
        .MAX_SNOOZE   (MAXS),
        .CNT_W        (W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .alarm_in  (alarm_in),
        .alarm_mask(alarm_mask),
        .weekday   (weekday),
        .snooze    (snooze),
        .get_up    (get_up),
        .day_clr   (day_clr),
        .alarm_out (alarm_out),
        .state     (state),
        .alarm_src (alarm_src),
        .snooze_cnt(snooze_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = ASLEEP;
        m_src   = '0;
        m_cnt   = 0;
        m_since = 0;
    endtask

    // One clock edge of the user-level rules.
    task automatic model_edge();
        logic [N-1:0] armed;
        armed = alarm_in & alarm_mask;
        if (day_clr) begin
            model_reset();
            return;
        end
        case (m_state)
            ASLEEP: if (armed != 0) begin
                m_state = RINGING;
                m_src   = armed;
                m_cnt   = 0;
            end
            RINGING: begin
                if (get_up) m_state = UP;
                else if (SNZ && snooze && m_cnt < MAXS) begin
                    m_state = SNOOZING;
                    m_cnt   = m_cnt + 1;
                    m_since = 0;
                end else if (armed == 0) m_state = IN_BED;
            end
            SNOOZING: begin
                if (get_up) m_state = UP;
                else begin
                    m_since = m_since + 1;
                    if (m_since == SNZC) m_state = RINGING;
                end
            end
            IN_BED: begin
                if (weekday) m_state = UP;
                else if (armed != 0) m_state = RINGING;
            end
            default: m_state = m_state;
        endcase
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_state));
        chk("alarm_out", 32'(alarm_out), 32'(m_state == RINGING));
        chk("alarm_src", 32'(alarm_src), 32'(m_src));
        chk("snooze_cnt", 32'(snooze_cnt), 32'(m_cnt));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check_all();
    endtask

    // Reset pulse strictly between edges; outputs must clear without a clock.
    task automatic async_reset_pulse();
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("async_rst_alarm_out", 32'(alarm_out), 32'd0);
        chk("async_rst_state", 32'(state), 32'd0);
        check_all();
        #1 reset = 1'b1;
    endtask

    task automatic idle_inputs();
        alarm_in   = '0;
        alarm_mask = '0;
        weekday    = 1'b0;
        snooze     = 1'b0;
        get_up     = 1'b0;
        day_clr    = 1'b0;
    endtask

    initial begin
        int lowcnt;
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_alarm_out", 32'(alarm_out), 32'd0);
        check_all();
        #1 reset = 1'b1;

        // Masked channel must not ring; armed channel rings on the same edge.
        alarm_mask = 4'b0101;
        alarm_in   = 4'b0010;
        tick();
        chk("masked_stays_asleep", 32'(state), 32'd0);
        alarm_in = 4'b0110;
        tick();
        chk("armed_rings", 32'(alarm_out), 32'd1);
        chk("src_latched", 32'(alarm_src), 32'(4'b0100));

        // Four snooze pulses; the fourth exceeds the budget.
        for (int i = 0; i < 4; i++) begin
            snooze = 1'b1;
            tick();
            snooze = 1'b0;
            lowcnt = 0;
            while (!alarm_out && lowcnt < 40) begin
                lowcnt++;
                tick();
            end
            chk("snooze_quiet_cycles", 32'(lowcnt), (SNZ && i < 3) ? 32'(SNZC) : 32'd0);
            chk("snooze_count", 32'(snooze_cnt), SNZ ? 32'((i < 3) ? i + 1 : 3) : 32'd0);
        end
        chk("snooze_limit_ringing", 32'(state), 32'(RINGING));

        // Alarm lapses, then weekday forces get-up; later alarms are ignored.
        alarm_in = 4'b0000;
        tick();
        chk("lapse_in_bed", 32'(state), 32'(IN_BED));
        weekday = 1'b1;
        tick();
        chk("weekday_up", 32'(state), 32'(UP));
        weekday  = 1'b0;
        alarm_in = 4'b1111;
        alarm_mask = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        chk("up_no_ring", 32'(alarm_out), 32'd0);

        // day_clr beats get_up.
        day_clr = 1'b1;
        get_up  = 1'b1;
        tick();
        chk("day_clr_asleep", 32'(state), 32'd0);
        day_clr  = 1'b0;
        get_up   = 1'b0;
        alarm_in = 4'b0001;
        tick();
        // get_up beats snooze.
        snooze = 1'b1;
        get_up = 1'b1;
        tick();
        chk("getup_over_snooze", 32'(state), 32'(UP));
        snooze  = 1'b0;
        get_up  = 1'b0;
        day_clr = 1'b1;
        tick();
        day_clr = 1'b0;

        // Reset mid-episode.
        alarm_in = 4'b1000;
        tick();
        chk("ring_before_reset", 32'(alarm_out), 32'd1);
        async_reset_pulse();
        chk("reset_src_cleared", 32'(alarm_src), 32'd0);
        alarm_in = 4'b0000;
        tick();

        // Randomized phase.
        for (int i = 0; i < 1500; i++) begin
            alarm_mask = 4'($urandom);
            alarm_in   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0000;
            weekday    = ($urandom_range(0, 15) == 0);
            snooze     = ($urandom_range(0, 3) == 0);
            get_up     = ($urandom_range(0, 39) == 0);
            day_clr    = ($urandom_range(0, 59) == 0);
            tick();
            if ($urandom_range(0, 149) == 0) async_reset_pulse();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_clock_multi.md
ALARM_CLOCK_MULTI -- requirements
Module: alarm_clock_multi

Interface
REQ-001 Parameter N_ALARMS, default 4: number of independent alarm channels (1..16).
REQ-002 Parameter SNOOZE_CYCLES, default 8: snooze interval in clk cycles (>=1).
REQ-003 Parameter MAX_SNOOZE, default 3: maximum snoozes per wake-up episode (<= 2**CNT_W-1).
REQ-004 Parameter CNT_W, default 4: width of snooze timer and snooze counter (2**CNT_W > SNOOZE_CYCLES-1).
REQ-005 clk  input  1  single clock; all state changes on posedge.
REQ-006 reset  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-007 alarm_in  input  N_ALARMS  per-channel alarm request, level-sensitive.
REQ-008 alarm_mask  input  N_ALARMS  per-channel enable; 1 = channel armed.
REQ-009 weekday  input  1  1 = working day; forces get-up from AWAKE_IN_BED.
REQ-010 snooze  input  1  snooze button, sampled on posedge.
REQ-011 get_up  input  1  user-up button, sampled on posedge.
REQ-012 day_clr  input  1  synchronous return to ASLEEP for the next day.
REQ-013 alarm_out  output  1  ringing indication.
REQ-014 state  output  3  current state encoding.
REQ-015 alarm_src  output  N_ALARMS  latched bitmap of channels that started the current ringing episode.
REQ-016 snooze_cnt  output  CNT_W  snoozes used in current episode.

Function
REQ-017 States SHALL be ASLEEP=3'd0, RINGING=3'd1, SNOOZING=3'd2, AWAKE_IN_BED=3'd3, AWAKE_AND_UP=3'd4; codes 5..7 SHALL go to ASLEEP next edge with alarm_out=0.
REQ-018 Define hit = |(alarm_in & alarm_mask); unmasked channels SHALL never affect state.
REQ-019 alarm_out SHALL be decoded from the state register only: 1 iff state==RINGING (Moore, no input-to-output path).
REQ-020 ASLEEP: hit -> RINGING, alarm_src <= alarm_in & alarm_mask, snooze_cnt <= 0; else stay.
REQ-021 RINGING priority: get_up -> AWAKE_AND_UP; else snooze and snooze_cnt<MAX_SNOOZE -> SNOOZING, timer <= SNOOZE_CYCLES-1, snooze_cnt++; else !hit -> AWAKE_IN_BED; else stay.
REQ-022 snooze with snooze_cnt==MAX_SNOOZE SHALL be ignored (stay RINGING while hit).
REQ-023 SNOOZING: get_up -> AWAKE_AND_UP; else timer==0 -> RINGING regardless of hit; else timer--; alarm_in ignored.
REQ-024 AWAKE_IN_BED: weekday -> AWAKE_AND_UP; else hit -> RINGING (alarm_src and snooze_cnt kept); else stay.
REQ-025 AWAKE_AND_UP: stay; alarm_in, snooze, weekday ignored.
REQ-026 day_clr SHALL have highest priority in every state: next state ASLEEP, timer, snooze_cnt, alarm_src cleared.
REQ-027 Latency: hit sampled at edge k SHALL give alarm_out=1 from edge k until state leaves RINGING.
REQ-028 Snooze interval: alarm_out low for exactly SNOOZE_CYCLES cycles between snooze edge and re-ring.
REQ-029 Timer and snooze_cnt SHALL not wrap; snooze_cnt saturates at MAX_SNOOZE.

Reset
REQ-030 reset low SHALL immediately force state=ASLEEP, alarm_out=0, alarm_src=0, snooze_cnt=0, timer=0, independent of clk.
REQ-031 Reset deassertion SHALL take effect at the first posedge after reset goes high; reset mid-episode SHALL discard all episode context.

Configuration
REQ-032 Macro ALARM_SNOOZE_EN defined: snooze behaviour per REQ-021..REQ-023, REQ-028.
REQ-033 ALARM_SNOOZE_EN undefined: snooze input ignored, SNOOZING unreachable, timer logic absent, snooze_cnt tied 0; all other behaviour identical.

Verification (defaults, ALARM_SNOOZE_EN defined unless noted)
REQ-034 reset low mid-RINGING between edges -> alarm_out=0, state=0 before next posedge; alarm_src=0.
REQ-035 mask=4'b0101, alarm_in=4'b0010 -> stays ASLEEP; alarm_in=4'b0110 -> RINGING same edge, alarm_src=4'b0100.
REQ-036 RINGING, snooze pulse 1 cycle -> alarm_out low exactly 8 cycles, back to RINGING, snooze_cnt=1; fourth snooze at snooze_cnt=3 ignored.
REQ-037 RINGING, alarm_in->0, weekday=0 -> AWAKE_IN_BED; weekday=1 -> AWAKE_AND_UP next edge; alarm_in=1 afterwards -> no ring.
REQ-038 get_up and snooze same edge in RINGING -> AWAKE_AND_UP; day_clr with get_up in any state -> ASLEEP, counters 0.
REQ-039 ALARM_SNOOZE_EN undefined: snooze pulses in RINGING -> stays RINGING, snooze_cnt=0, state never 2.
